// File: rtl/sb_3320_turn_command_gen.sv
// Line-follower turn command generator: synchronises and debounces three line
// sensors, then steers through follow/node/search states and stops after a target node count or a lost-line timeout.
module sb_3320_turn_command_gen #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LOST_TIMEOUT    = 25000000,
    parameter int NODE_TARGET     = 4
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] sensor,
    output logic [2:0] turn,
    output logic [3:0] node_count,
    output logic       node_pulse,
    output logic       done,
    output logic       lost
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(LOST_TIMEOUT + 1);

    localparam logic [2:0] TURN_STOP    = 3'b000;
    localparam logic [2:0] TURN_FORWARD = 3'b001;
    localparam logic [2:0] TURN_LEFT    = 3'b010;
    localparam logic [2:0] TURN_RIGHT   = 3'b011;
    localparam logic [2:0] TURN_EXTREME = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FOLLOW,
        ST_NODE,
        ST_SEARCH,
        ST_DONE
    } state_t;

    logic [2:0]      sync1_reg;
    logic [2:0]      s_sync_reg;
    logic [2:0]      s_db_reg;
    logic [DB_W-1:0] db_cnt_reg;
    logic [TO_W-1:0] lost_timer_reg;
    state_t          state_reg;
    logic [2:0]      turn_reg;
    logic [3:0]      node_count_reg;
    logic            node_pulse_reg;
    logic            done_reg;
    logic            lost_reg;
    logic            lost_hit_reg;

    // Per-bit two-flop synchroniser; each comparator is asynchronous to clk_50.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            always_ff @(posedge clk_50) begin
                if (reset) begin
                    sync1_reg[gi]  <= 1'b0;
                    s_sync_reg[gi] <= 1'b0;
                end else begin
                    sync1_reg[gi]  <= sensor[gi];
                    s_sync_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    // The incoming sample is compared against the current synchronised value,
    // so the count restarts on the same edge that s_sync takes a new pattern.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            db_cnt_reg <= '0;
            s_db_reg   <= 3'b000;
        end else if (sync1_reg != s_sync_reg) begin
            db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            s_db_reg <= s_sync_reg;
        end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            turn_reg       <= TURN_STOP;
            node_count_reg <= 4'd0;
            node_pulse_reg <= 1'b0;
            done_reg       <= 1'b0;
            lost_reg       <= 1'b0;
            lost_hit_reg   <= 1'b0;
            lost_timer_reg <= '0;
        end else begin
            node_pulse_reg <= 1'b0;
            done_reg       <= (state_reg == ST_DONE);
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    turn_reg <= TURN_STOP;
                    if (state_reg == ST_DONE) begin
                        lost_reg <= lost_hit_reg;
                    end
                    if (start) begin
                        state_reg      <= ST_FOLLOW;
                        node_count_reg <= 4'd0;
                        lost_reg       <= 1'b0;
                        lost_hit_reg   <= 1'b0;
                    end
                end
                ST_FOLLOW: begin
                    case (s_db_reg)
                        3'b010:         turn_reg <= TURN_FORWARD;
                        3'b110, 3'b100: turn_reg <= TURN_LEFT;
                        3'b011, 3'b001: turn_reg <= TURN_RIGHT;
                        3'b111: begin
                            turn_reg       <= TURN_FORWARD;
                            node_pulse_reg <= 1'b1;
                            state_reg      <= ST_NODE;
                            if (node_count_reg != 4'd15) begin
                                node_count_reg <= node_count_reg + 1'b1;
                            end
                        end
                        3'b000: begin
                            state_reg      <= ST_SEARCH;
                            lost_timer_reg <= '0;
                        end
                        default: turn_reg <= turn_reg;  // 101: hold previous steering
                    endcase
                end
                ST_NODE: begin
                    turn_reg <= TURN_FORWARD;
                    if (s_db_reg != 3'b111) begin
                        if (NODE_TARGET != 0 && node_count_reg == 4'(NODE_TARGET)) begin
                            state_reg    <= ST_DONE;
                            lost_hit_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_FOLLOW;
                        end
                    end
                end
                ST_SEARCH: begin
                    turn_reg <= TURN_EXTREME;
                    // Reacquiring the line wins over a simultaneous timeout.
                    if (s_db_reg != 3'b000) begin
                        state_reg      <= ST_FOLLOW;
                        lost_timer_reg <= '0;
                    end else if (lost_timer_reg == TO_W'(LOST_TIMEOUT - 1)) begin
                        state_reg    <= ST_DONE;
                        lost_hit_reg <= 1'b1;
                    end else begin
                        lost_timer_reg <= lost_timer_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign turn       = turn_reg;
    assign node_count = node_count_reg;
    assign node_pulse = node_pulse_reg;
    assign done       = done_reg;
    assign lost       = lost_reg;

endmodule

// File: tb/tb_sb_3320_turn_command_gen.sv
// Directed bench for the turn command generator with short debounce and timeout
// parameters so every scenario fits in a few hundred cycles.
module tb_sb_3320_turn_command_gen;

    logic       clk_50 = 1'b0;
    logic       reset  = 1'b1;
    logic       start  = 1'b0;
    logic [2:0] sensor = 3'b010;
    logic [2:0] turn;
    logic [3:0] node_count;
    logic       node_pulse;
    logic       done;
    logic       lost;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    sb_3320_turn_command_gen #(
        .DEBOUNCE_CYCLES(4),
        .LOST_TIMEOUT(20),
        .NODE_TARGET(2)
    ) dut (
        .clk_50(clk_50),
        .reset(reset),
        .start(start),
        .sensor(sensor),
        .turn(turn),
        .node_count(node_count),
        .node_pulse(node_pulse),
        .done(done),
        .lost(lost)
    );

    always #5 clk_50 = ~clk_50;

    always @(negedge clk_50) begin
        if (node_pulse) pulse_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 100000");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks++;
            if (turn !== 3'b000 || done !== 1'b0 || node_count !== 4'd0 || node_pulse !== 1'b0 || lost !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: turn=%b done=%b count=%0d pulse=%b lost=%b, required 000 0 0 0 0",
                         turn, done, node_count, node_pulse, lost);
            end
        end
        reset = 1'b0;
        tick(10);
        checks++;
        if (turn !== 3'b000 || done !== 1'b0 || node_count !== 4'd0) begin
            errors++;
            $display("FAIL idle_no_start: turn=%b done=%b count=%0d, required 000 0 0", turn, done, node_count);
        end
        $display("test_reset done");
    endtask

    task automatic step_turn(input logic [2:0] pattern, input logic [2:0] old_turn, input logic [2:0] new_turn);
        sensor = pattern;
        tick(6);
        checks++;
        if (turn !== old_turn) begin
            errors++;
            $display("FAIL turn_before_%b: turn=%b, required %b", pattern, turn, old_turn);
        end
        tick(1);
        checks++;
        if (turn !== new_turn) begin
            errors++;
            $display("FAIL turn_after_%b: turn=%b, required %b", pattern, turn, new_turn);
        end
        tick(3);
        $display("sensor %b -> turn %b", pattern, turn);
    endtask

    task automatic test_follow();
        pulse_start();
        tick(1);
        checks++;
        if (turn !== 3'b001) begin
            errors++;
            $display("FAIL follow_forward: turn=%b, required 001", turn);
        end
        step_turn(3'b110, 3'b001, 3'b010);
        step_turn(3'b011, 3'b010, 3'b011);
    endtask

    task automatic test_node();
        sensor = 3'b111;
        tick(7);
        checks++;
        if (node_count !== 4'd1 || node_pulse !== 1'b1 || turn !== 3'b001) begin
            errors++;
            $display("FAIL node1_entry: count=%0d pulse=%b turn=%b, required 1 1 001", node_count, node_pulse, turn);
        end
        tick(8);
        sensor = 3'b010;
        tick(10);
        checks++;
        if (pulse_cnt !== 1 || node_count !== 4'd1 || done !== 1'b0 || turn !== 3'b001) begin
            errors++;
            $display("FAIL node1_once: pulses=%0d count=%0d done=%b turn=%b, required 1 1 0 001",
                     pulse_cnt, node_count, done, turn);
        end
        $display("node 1 counted, count=%0d", node_count);
        sensor = 3'b111;
        tick(10);
        checks++;
        if (node_count !== 4'd2 || turn !== 3'b001 || done !== 1'b0) begin
            errors++;
            $display("FAIL node2_entry: count=%0d turn=%b done=%b, required 2 001 0", node_count, turn, done);
        end
        sensor = 3'b010;
        tick(10);
        checks++;
        if (turn !== 3'b000 || done !== 1'b1 || lost !== 1'b0 || node_count !== 4'd2 || pulse_cnt !== 2) begin
            errors++;
            $display("FAIL node_target_done: turn=%b done=%b lost=%b count=%0d pulses=%0d, required 000 1 0 2 2",
                     turn, done, lost, node_count, pulse_cnt);
        end
        $display("node target reached, done=%b", done);
    endtask

    task automatic test_search_timeout();
        pulse_start();
        tick(1);
        checks++;
        if (node_count !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: count=%0d done=%b, required 0 0", node_count, done);
        end
        sensor = 3'b000;
        tick(10);
        checks++;
        if (turn !== 3'b100 || done !== 1'b0) begin
            errors++;
            $display("FAIL search_extreme: turn=%b done=%b, required 100 0", turn, done);
        end
        tick(17);
        checks++;
        if (done !== 1'b0 || turn !== 3'b100) begin
            errors++;
            $display("FAIL search_pre_timeout: done=%b turn=%b, required 0 100", done, turn);
        end
        tick(1);
        checks++;
        if (done !== 1'b1 || lost !== 1'b1 || turn !== 3'b000) begin
            errors++;
            $display("FAIL search_timeout: done=%b lost=%b turn=%b, required 1 1 000", done, lost, turn);
        end
        tick(2);
        $display("search timeout, lost=%b", lost);
    endtask

    task automatic test_search_recover();
        sensor = 3'b010;
        tick(10);
        pulse_start();
        tick(1);
        checks++;
        if (turn !== 3'b001 || done !== 1'b0 || lost !== 1'b0) begin
            errors++;
            $display("FAIL recover_restart: turn=%b done=%b lost=%b, required 001 0 0", turn, done, lost);
        end
        sensor = 3'b000;
        tick(17);
        sensor = 3'b001;
        tick(7);
        checks++;
        if (turn !== 3'b100) begin
            errors++;
            $display("FAIL recover_still_search: turn=%b, required 100", turn);
        end
        tick(1);
        checks++;
        if (turn !== 3'b011) begin
            errors++;
            $display("FAIL recover_right: turn=%b, required 011", turn);
        end
        tick(20);
        checks++;
        if (done !== 1'b0 || lost !== 1'b0 || turn !== 3'b011) begin
            errors++;
            $display("FAIL recover_no_timeout: done=%b lost=%b turn=%b, required 0 0 011", done, lost, turn);
        end
        $display("search recovered, turn=%b", turn);
    endtask

    task automatic test_glitch();
        sensor = 3'b010;
        tick(10);
        checks++;
        if (turn !== 3'b001) begin
            errors++;
            $display("FAIL glitch_setup: turn=%b, required 001", turn);
        end
        sensor = 3'b000;
        tick(2);
        sensor = 3'b010;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            checks++;
            if (turn !== 3'b001) begin
                errors++;
                $display("FAIL glitch_cycle%0d: turn=%b, required 001", i, turn);
            end
        end
        $display("glitch filtered, turn=%b", turn);
    endtask

    task automatic test_reset_midrun();
        sensor = 3'b111;
        tick(10);
        checks++;
        if (node_count !== 4'd1 || turn !== 3'b001) begin
            errors++;
            $display("FAIL midrun_node: count=%0d turn=%b, required 1 001", node_count, turn);
        end
        reset = 1'b1;
        start = 1'b1;
        tick(1);
        checks++;
        if (turn !== 3'b000 || node_count !== 4'd0 || done !== 1'b0 || lost !== 1'b0 || node_pulse !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: turn=%b count=%0d done=%b lost=%b pulse=%b, required 000 0 0 0 0",
                     turn, node_count, done, lost, node_pulse);
        end
        reset = 1'b0;
        start = 1'b0;
        tick(10);
        checks++;
        if (turn !== 3'b000 || node_count !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_idle: turn=%b count=%0d done=%b, required 000 0 0", turn, node_count, done);
        end
        $display("reset mid-run, turn=%b count=%0d", turn, node_count);
    endtask

    initial begin
        test_reset();
        test_follow();
        test_node();
        test_search_timeout();
        test_search_recover();
        test_glitch();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
